// File: rtl/eth_pkg.sv
// Shared Ethernet constants and transmit FSM state type for the MII TX/RX paths.
package eth_pkg;

  localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB20E3;
  localparam int          ETH_MIN_LEN      = 60;
  localparam int          ETH_PRE_NIBS     = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

endpackage

// File: rtl/eth_crc32_nib.sv
// Combinational reflected CRC-32 update for one nibble, LSB first.
module eth_crc32_nib
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  nib_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 4; i++) begin
      if (crc_o[0] ^ nib_i[i]) crc_o = (crc_o >> 1) ^ CRC32_POLY_REFL;
      else                     crc_o = crc_o >> 1;
    end
  end

endmodule

// File: rtl/eth_mii_tx.sv
// MII transmit path: streams a frame from the TX RAM with preamble, padding,
// FCS and inter-frame gap.
module eth_mii_tx
  import eth_pkg::*;
#(
  parameter int MTU     = 1536,
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int IFG_NIB = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nib_en,
  input  logic              start,
  input  logic [15:0]       len,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              buf_rd,
  input  logic [7:0]        buf_data,
  output logic [3:0]        mii_txd,
  output logic              mii_tx_en,
  output logic              mii_tx_er
);

  localparam logic [15:0] MTU_W     = 16'(MTU);
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [4:0]  PRE_LAST  = 5'(ETH_PRE_NIBS - 1);
  localparam logic [4:0]  IFG_LAST  = 5'(IFG_NIB);

  tx_state_e         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic              hi_q, hi_d;
  logic [3:0]        hold_q, hold_d;
  logic [31:0]       crc_q, crc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              len_err_q, len_err_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic              buf_rd_q, buf_rd_d;
  logic [3:0]        txd_q, txd_d;
  logic              tx_en_q, tx_en_d;

  logic [3:0]        data_nib;
  logic [31:0]       crc_next;
  logic [31:0]       fcs;
  logic [15:0]       byte_inc;

  assign data_nib = (state_q == ST_PAD) ? 4'h0 : (hi_q ? hold_q : buf_data[3:0]);
  assign byte_inc = byte_cnt_q + 16'd1;
  assign fcs      = ~crc_q;

  eth_crc32_nib u_crc (
    .crc_i (crc_q),
    .nib_i (data_nib),
    .crc_o (crc_next)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    hi_d       = hi_q;
    hold_d     = hold_q;
    crc_d      = crc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    len_err_d  = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_rd_d   = buf_rd_q;
    txd_d      = txd_q;
    tx_en_d    = tx_en_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == 16'd0 || len > MTU_W) begin
            len_err_d = 1'b1;
          end else begin
            len_d      = len;
            busy_d     = 1'b1;
            buf_addr_d = '0;
            buf_rd_d   = 1'b1;
            crc_d      = 32'hFFFF_FFFF;
            cnt_d      = '0;
            byte_cnt_d = '0;
            hi_d       = 1'b0;
            state_d    = ST_PRE;
          end
        end
      end
      ST_PRE: if (nib_en) begin
        txd_d   = ETH_PREAMBLE_NIB;
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SFD;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_SFD: if (nib_en) begin
        txd_d   = ETH_SFD_NIB;
        state_d = ST_DATA;
      end
      ST_DATA, ST_PAD: if (nib_en) begin
        txd_d = data_nib;
        crc_d = crc_next;
        if (!hi_q) begin
          hi_d   = 1'b1;
          hold_d = buf_data[7:4];
          // Advance on the low nibble so the registered RAM read settles
          // before the next byte's low-nibble tick, even at full rate.
          if (state_q == ST_DATA && byte_inc != len_q)
            buf_addr_d = byte_inc[ADDR_W-1:0];
        end else begin
          hi_d       = 1'b0;
          byte_cnt_d = byte_inc;
          if (state_q == ST_DATA && byte_inc == len_q) begin
            buf_rd_d = 1'b0;
            state_d  = (len_q < MIN_LEN_W) ? ST_PAD : ST_FCS;
          end else if (state_q == ST_PAD && byte_inc == MIN_LEN_W) begin
            state_d = ST_FCS;
          end
        end
      end
      ST_FCS: if (nib_en) begin
        txd_d = fcs[{cnt_q[2:0], 2'b00} +: 4];
        if (cnt_q == 5'd7) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_IFG: if (nib_en) begin
        txd_d   = 4'h0;
        tx_en_d = 1'b0;
        // The first tick drops tx_en; the line then idles IFG_NIB full ticks.
        if (cnt_q == IFG_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      hi_q       <= 1'b0;
      hold_q     <= '0;
      crc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_rd_q   <= 1'b0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      hi_q       <= hi_d;
      hold_q     <= hold_d;
      crc_q      <= crc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      buf_addr_q <= buf_addr_d;
      buf_rd_q   <= buf_rd_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign len_err   = len_err_q;
  assign buf_addr  = buf_addr_q;
  assign buf_rd    = buf_rd_q;
  assign mii_txd   = txd_q;
  assign mii_tx_en = tx_en_q;
  assign mii_tx_er = 1'b0;

endmodule

// File: tb/tb_eth_mii_tx.sv
// Scoreboard bench for eth_mii_tx: expected nibble stream queued at start,
// popped on every transmitted nibble; FCS also checked by CRC residue.
module tb_eth_mii_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nib_en = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic        busy, done, len_err, buf_rd, mii_tx_en, mii_tx_er;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;
  logic [3:0]  mii_txd;

  logic [7:0]  ram [0:2047];

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  int         exp_ticks = 0;
  int         div = 1;
  int         nib_cnt = 0;
  int         cyc = 0;
  int         en_ticks = 0;
  int         nib_idx = 0;
  int         frames = 0;
  int         done_cnt = 0;
  int         fall_cyc = 0;
  logic       prev_en = 1'b0;
  logic       prev_done = 1'b0;
  logic [3:0] prev_txd = 4'h0;
  logic [31:0] rx_crc = 32'hFFFF_FFFF;

  eth_mii_tx dut (
    .clk       (clk),
    .rst       (rst),
    .nib_en    (nib_en),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err),
    .buf_addr  (buf_addr),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data),
    .mii_txd   (mii_txd),
    .mii_tx_en (mii_tx_en),
    .mii_tx_er (mii_tx_er)
  );

  always #5 clk = ~clk;

  always @(posedge clk) buf_data <= ram[buf_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'h0, n};
    for (int k = 0; k < 4; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Monitor: samples on the falling edge, nib_en reflects the preceding rising edge.
  always @(negedge clk) begin
    logic [3:0] e;
    cyc++;
    if (rst) begin
      prev_en   = 1'b0;
      prev_done = 1'b0;
      prev_txd  = 4'h0;
      nib_idx   = 0;
    end else begin
      if (nib_en) begin
        if (mii_tx_en) begin
          if (!prev_en) begin
            frames++;
            en_ticks = 0;
            nib_idx  = 0;
            rx_crc   = 32'hFFFF_FFFF;
          end
          check_eq("nib_queue", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("nib%0d", nib_idx), {28'h0, mii_txd}, {28'h0, e});
          end
          if (nib_idx >= 16) rx_crc = crc_nib(rx_crc, mii_txd);
          en_ticks++;
          nib_idx++;
        end
      end else begin
        check_eq("hold", {27'h0, mii_tx_en, mii_txd}, {27'h0, prev_en, prev_txd});
      end
      if (prev_en && !mii_tx_en) begin
        check_eq("en_ticks", en_ticks, exp_ticks);
        check_eq("residue", rx_crc, 32'hDEBB20E3);
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("tx_er", {31'h0, mii_tx_er}, 32'h0);
        fall_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check_eq("done_gap", cyc - fall_cyc, 24 * div);
        check_eq("done_1cyc", {31'h0, prev_done}, 32'h0);
      end
      prev_en   = mii_tx_en;
      prev_txd  = mii_txd;
      prev_done = done;
    end
    nib_cnt = (nib_cnt + 1) % div;
    nib_en  = (nib_cnt == 0);
  end

  task automatic send(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    int          tot;
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    c   = 32'hFFFF_FFFF;
    tot = (n < 60) ? 60 : n;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? ram[i] : 8'h00;
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
    exp_ticks = 16 + 2 * tot + 8;
    @(negedge clk);
    start = 1'b1;
    len   = n[15:0];
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", {31'h0, busy}, 32'h1);
    check_eq("start_addr", {21'h0, buf_addr}, 32'h0);
    check_eq("start_no_err", {31'h0, len_err}, 32'h0);
  endtask

  task automatic send_bad(input int n);
    int f0;
    f0 = frames;
    @(negedge clk);
    start = 1'b1;
    len   = n[15:0];
    @(negedge clk);
    start = 1'b0;
    check_eq("len_err_pulse", {31'h0, len_err}, 32'h1);
    check_eq("len_err_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check_eq("len_err_1cyc", {31'h0, len_err}, 32'h0);
    repeat (40) @(negedge clk);
    check_eq("len_err_noframe", frames, f0);
    check_eq("len_err_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1'b1;
    len   = n[15:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq("done_seen", done_cnt - d0, 1);
    @(negedge clk);
    check_eq("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_nibs(input int n);
    int k;
    k = 0;
    while (nib_idx < n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check_eq("nib_wait", 32'(nib_idx >= n), 32'd1);
  endtask

  initial begin
    string s;
    int    f0;
    int    d0;
    int    k;

    #1 rst = 1'b1;
    #2;
    check_eq("rst_outputs",
             {17'h0, busy, done, len_err, buf_rd, mii_tx_en, mii_tx_er, mii_txd, buf_addr[5:0]},
             32'h0);
    check_eq("rst_addr", {21'h0, buf_addr}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // len=100 incrementing data, full rate
    for (int i = 0; i < 2048; i++) ram[i] = i[7:0];
    send(100);
    wait_done(2000);
    $display("[TB] frame len=100 full rate, done_cnt=%0d", done_cnt);

    // len=9 "123456789", padded to 60
    s = "123456789";
    for (int i = 0; i < 9; i++) ram[i] = s[i];
    send(9);
    wait_done(2000);
    $display("[TB] frame len=9 padded, done_cnt=%0d", done_cnt);

    // rejected lengths
    send_bad(0);
    $display("[TB] start len=0 rejected");
    send_bad(1537);
    $display("[TB] start len=1537 rejected");

    // nib_en every 4th cycle
    for (int i = 0; i < 2048; i++) ram[i] = i[7:0];
    div = 4;
    send(64);
    wait_done(8000);
    repeat (8) @(negedge clk);
    div = 1;
    $display("[TB] frame len=64 quarter rate, done_cnt=%0d", done_cnt);

    // start re-asserted during DATA and IFG
    f0 = frames;
    d0 = done_cnt;
    send(100);
    wait_nibs(50);
    pulse_start(30);
    k = 0;
    while (mii_tx_en && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("fall_wait", {31'h0, mii_tx_en}, 32'h0);
    repeat (5) @(negedge clk);
    pulse_start(30);
    wait_done(2000);
    repeat (80) @(negedge clk);
    check_eq("one_frame", frames - f0, 1);
    check_eq("one_done", done_cnt - d0, 1);
    $display("[TB] restart-while-busy ignored, frames=%0d", frames - f0);

    // reset mid-DATA, then a fresh len=60 frame
    d0 = done_cnt;
    send(100);
    wait_nibs(60);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_txen", {31'h0, mii_tx_en}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("abort_no_done", done_cnt - d0, 0);
    f0 = frames;
    send(60);
    wait_done(2000);
    check_eq("post_rst_frame", frames - f0, 1);
    $display("[TB] reset mid-frame then len=60, done_cnt=%0d", done_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
